// File: rtl/switch_pkg.sv
// switch_pkg: packet type, destination-mask field and port count shared by the ingress block
package switch_pkg;
   localparam int PORTS    = 4;
   localparam int PKT_W    = 16;
   localparam int DEST_LSB = 0;
   localparam int DEST_MSB = DEST_LSB + PORTS - 1;
   typedef logic [PKT_W-1:0] pkt_t;
   typedef logic [PORTS-1:0] dest_t;
   function automatic dest_t dest_of(input pkt_t p);
      return p[DEST_MSB:DEST_LSB];
   endfunction
endpackage

// File: rtl/switch_ingress_if.sv
// switch_ingress_if: source handshake and switch-port launch signals
//   master : source/switch side (drives src_valid, src_data, ip_suspend)
//   slave  : ingress block side (drives src_ready, ip_valid, ip_data)
interface switch_ingress_if;
   import switch_pkg::*;
   logic src_valid;
   logic src_ready;
   pkt_t src_data;
   logic ip_valid;
   pkt_t ip_data;
   logic ip_suspend;
   modport master (output src_valid, src_data, ip_suspend, input src_ready, ip_valid, ip_data);
   modport slave  (input src_valid, src_data, ip_suspend, output src_ready, ip_valid, ip_data);
endinterface

// File: rtl/ingress_fifo.sv
// ingress_fifo: circular packet FIFO of any depth (not limited to powers of two)
//   clk, reset      : clock, asynchronous active-high reset (empties the FIFO)
//   push, wr_data   : write at tail, ignored when full
//   pop, rd_data    : rd_data is the head word, pop removes it, ignored when empty
//   full, empty, count : occupancy status
module ingress_fifo
   import switch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  pkt_t                         wr_data,
   input  logic                         pop,
   output pkt_t                         rd_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   pkt_t mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= wr_data;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= do_push ? ((wr_ptr == LAST) ? '0 : wr_ptr + 1'b1) : wr_ptr;
         rd_ptr <= do_pop ? ((rd_ptr == LAST) ? '0 : rd_ptr + 1'b1) : rd_ptr;
         count  <= count + CW'(do_push) - CW'(do_pop);
      end
endmodule

// File: rtl/switch_ingress.sv
// switch_ingress: filters and queues source packets, launches them one per pulse into a switch port
//   clk, reset  : clock, asynchronous active-high reset
//   bus (slave) : src_valid/src_data/src_ready from the source; ip_valid/ip_data/ip_suspend to the switch
//   in_cnt, out_cnt, drop_cnt : accepted, delivered and dropped packet counts, wrapping at 2^16
module switch_ingress
   import switch_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int MIN_GAP    = 0
) (
   input  logic            clk,
   input  logic            reset,
   switch_ingress_if.slave bus,
   output logic [15:0]     in_cnt,
   output logic [15:0]     out_cnt,
   output logic [15:0]     drop_cnt
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2;
   localparam logic GAP_EN = MIN_GAP > 0;
   logic [1:0] state;
   logic [3:0] gap_cnt;
   logic [CW-1:0] occ;
   logic full, empty, take, push, pop, may_launch;
   pkt_t head;
   assign bus.src_ready = occ < CW'(FIFO_DEPTH);
   assign take = bus.src_valid && !full;
   assign push = take && dest_of(bus.src_data) != '0;
   // Launch points: IDLE, straight out of SEND when no gap is required, and the
   // last GAP cycle, so exactly MIN_GAP idle cycles separate consecutive packets.
   assign may_launch = state == IDLE || (state == SEND && !GAP_EN) || (state == GAP && gap_cnt == 4'd1);
   assign pop = may_launch && !empty && !bus.ip_suspend;
   ingress_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .wr_data (bus.src_data),
      .pop     (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .count   (occ)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state        <= IDLE;
         gap_cnt      <= '0;
         bus.ip_valid <= 1'b0;
         bus.ip_data  <= '0;
         in_cnt       <= '0;
         out_cnt      <= '0;
         drop_cnt     <= '0;
      end else begin
         bus.ip_valid <= pop;
         if (pop) bus.ip_data <= head;
         state    <= pop ? SEND : (state == SEND && GAP_EN) ? GAP : (state == GAP && gap_cnt > 4'd1) ? GAP : IDLE;
         gap_cnt  <= (state == SEND && GAP_EN) ? 4'(MIN_GAP) : (state == GAP && gap_cnt > 4'd1) ? gap_cnt - 4'd1 : 4'd0;
         in_cnt   <= in_cnt + 16'(push);
         out_cnt  <= out_cnt + 16'(pop);
         drop_cnt <= drop_cnt + 16'(take && !push);
      end
endmodule
